// File: rtl/opctrl_param.sv
// rtl/opctrl_param.sv - parametrised even/odd output-port controller with per-polarity flit FIFOs
//
// Purpose:
//   Sits between the output arbiter and the link register of one router output port.
//   Each cycle it does two things:
//     * Write side: captures the one-hot-granted input flit into FIFO[polarity] and
//       returns a one-hot clear pulse to the winning input buffer.
//     * Read side: drains FIFO[~polarity] to the next hop.
//   Because the write and read sides always use different FIFOs, a push and a pop can
//   both happen in one cycle without ever touching the same FIFO.
//
// Parameters:
//   DATA_W  flit width in bits
//   NUM_IN  number of input channels (bit 0 = PE, then S, N, E, W)
//   DEPTH   entries per polarity FIFO, >=1 (non power of two allowed)
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high
//   polarity        0 = even cycle, 1 = odd cycle
//   grant           one-hot grant from the arbiter (0 = idle)
//   data_in         flattened inputs, slice i = [i*DATA_W +: DATA_W]
//   receive_output  next hop can accept a flit this cycle
//   data_out        registered output flit
//   send_output     registered, data_out valid this cycle
//   accept          comb, FIFO[polarity] not full
//   clear           comb, one-hot clear to the granted input
//   grant_err       registered, one-cycle pulse on a non-one-hot grant
//   cnt_even        occupancy of the even FIFO
//   cnt_odd         occupancy of the odd FIFO

module opctrl_param #(
    parameter int DATA_W = 64,
    parameter int NUM_IN = 5,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         polarity,
    input  logic [NUM_IN-1:0]            grant,
    input  logic [NUM_IN*DATA_W-1:0]     data_in,
    input  logic                         receive_output,
    output logic [DATA_W-1:0]            data_out,
    output logic                         send_output,
    output logic                         accept,
    output logic [NUM_IN-1:0]            clear,
    output logic                         grant_err,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_even,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_odd
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    // Storage and per-FIFO state; index 0 = even FIFO, index 1 = odd FIFO.
    logic [DATA_W-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [CNT_W-1:0]  cnt_q    [2];

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              send_q, send_d;
    logic              grant_err_q, grant_err_d;

    logic              wr_sel;
    logic              rd_sel;
    logic              grant_ok;
    logic              grant_bad;
    logic [IDX_W-1:0]  grant_idx;
    logic [DATA_W-1:0] push_data;
    logic              push;
    logic              pop;

    // Pointer advance with explicit wrap so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign wr_sel = polarity;
    assign rd_sel = ~polarity;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign grant_ok  = (grant != '0) && ((grant & (grant - NUM_IN'(1))) == '0);
    assign grant_bad = (grant != '0) && !grant_ok;

    // Binary index of the granted input; only meaningful when grant_ok.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign push_data = data_in[grant_idx*DATA_W +: DATA_W];

    // A full write FIFO ignores the grant silently; the arbiter holds or retries.
    assign accept = (cnt_q[wr_sel] != CNT_W'(DEPTH));
    assign clear  = (accept && grant_ok && !reset) ? grant : '0;
    assign push   = (clear != '0);
    assign pop    = receive_output && (cnt_q[rd_sel] != '0);

    // Next state of the registered outputs; data_out holds when nothing is sent.
    always_comb begin
        data_out_d  = data_out_q;
        send_d      = 1'b0;
        grant_err_d = grant_bad;
        if (pop) begin
            data_out_d = mem_q[rd_sel][rd_ptr_q[rd_sel]];
            send_d     = 1'b1;
        end
    end

    // Flit storage is not reset; push is already forced low while reset is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_sel][wr_ptr_q[wr_sel]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < 2; f++) begin
                wr_ptr_q[f] <= '0;
                rd_ptr_q[f] <= '0;
                cnt_q[f]    <= '0;
            end
            data_out_q  <= '0;
            send_q      <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            // wr_sel != rd_sel, so these two updates never target the same FIFO.
            if (push) begin
                wr_ptr_q[wr_sel] <= ptr_inc(wr_ptr_q[wr_sel]);
                cnt_q[wr_sel]    <= cnt_q[wr_sel] + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q[rd_sel] <= ptr_inc(rd_ptr_q[rd_sel]);
                cnt_q[rd_sel]    <= cnt_q[rd_sel] - CNT_W'(1);
            end
            data_out_q  <= data_out_d;
            send_q      <= send_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign send_output = send_q;
    assign grant_err   = grant_err_q;
    assign cnt_even    = cnt_q[0];
    assign cnt_odd     = cnt_q[1];

endmodule
